// File: rtl/mem_port_pkg.sv
// Shared types and constants for the memory port: request payload, default
// latency/depth, FSM state encodings and a small payload helper.
package mem_port_pkg;

    localparam int MEM_LAT    = 3;
    localparam int PORT_DEPTH = 4;
    localparam int ADDR_W     = 16;
    localparam int RESP_W     = 64;

    // One port's request toward the shared memory.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       din;
        logic              we;
    } data_in;

    // Port FSM states.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    // Forces the write enable low unless a request is actually being presented.
    function automatic data_in mask_we(input data_in d, input logic active);
        data_in r;
        r    = d;
        r.we = d.we & active;
        return r;
    endfunction

endpackage

// File: rtl/mem_port_resp_fifo.sv
// Response FIFO: holds {upper, lower} read data until writeback takes it.
// Pointers wrap modulo DEPTH; the head reads as zero while empty.
module resp_fifo
    import mem_port_pkg::*;
#(
    parameter int DEPTH = PORT_DEPTH
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    push,
    input  logic [RESP_W-1:0]       push_data,
    input  logic                    pop,
    output logic [RESP_W-1:0]       head,
    output logic                    not_empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [RESP_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              pop_ok;
    logic              full;

    assign not_empty = (count != '0);
    assign full      = (count == CW'(DEPTH));
    assign pop_ok    = pop && not_empty;
    assign head      = not_empty ? mem[rd_ptr] : '0;

    // Storage array; contents are don't-care while the count says empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; push and pop together keep the count unchanged.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (push && !pop_ok) begin
                count <= count + 1'b1;
            end else if (!push && pop_ok) begin
                count <= count - 1'b1;
            end
        end
    end

    // Upstream credit accounting guarantees a free slot for every arriving response.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (rstn) !(push && full));

endmodule

// File: rtl/mem_port.sv
// Memory port between the pipeline MEM stage and a shared memory arbiter.
// Holds one request, pulses it to the arbiter, tracks grants through a
// LAT-deep valid pipe and buffers returned data in a response FIFO.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both high; valid must stay high with stable payload until that edge,
// and ready may depend combinationally on the current cycle's inputs.
module mem_port
    import mem_port_pkg::*;
#(
    parameter int LAT   = MEM_LAT,
    parameter int DEPTH = PORT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  data_in                 req_u,
    input  data_in                 req_l,
    output logic                   mem_req_now,
    input  logic                   mem_wait,
    output data_in                 u_data_in,
    output data_in                 l_data_in,
    input  logic [31:0]            u_data_out,
    input  logic [31:0]            l_data_out,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [31:0]            resp_u,
    output logic [31:0]            resp_l,
    output logic                   interlock,
    output logic                   busy,
    output logic [1:0]             state_dbg,
    output logic [$clog2(DEPTH):0] fifo_count_dbg
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    data_in            hold_u;
    data_in            hold_l;
    logic [LAT-1:0]    grant_sr;
    logic [CW-1:0]     fifo_count;
    logic [CW-1:0]     inflight;
    logic [CW-1:0]     outstanding;
    logic [RESP_W-1:0] fifo_head;
    logic              held;
    logic              grant;
    logic              accept;
    logic              fifo_push;
    logic              fifo_pop;

    // A request sits in the hold register from ISSUE until it is granted.
    assign held   = (state == ST_ISSUE) || (state == ST_WAIT);
    assign grant  = held && !mem_wait;
    assign accept = req_valid && req_ready;

    // Count grants still travelling through the latency pipe.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + CW'(grant_sr[i]);
        end
    end

    // Every request is counted from acceptance until writeback pops its response,
    // so the FIFO always has room for whatever is still in flight.
    assign outstanding = CW'(held) + inflight + fifo_count;

    assign req_ready   = !rstn && ((state == ST_IDLE) || grant) && (outstanding < CW'(DEPTH));
    assign interlock   = req_valid && !req_ready;
    assign busy        = (outstanding != '0);
    assign mem_req_now = (state == ST_ISSUE);
    assign u_data_in   = mask_we(hold_u, held);
    assign l_data_in   = mask_we(hold_l, held);
    assign state_dbg   = state;

    // Next-state selection; a grant with a fresh acceptance goes straight back to ISSUE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE, ST_WAIT: begin
                if (!mem_wait) begin
                    state_nxt = accept ? ST_ISSUE : ST_IDLE;
                end else begin
                    state_nxt = ST_WAIT;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Hold register captures the request on acceptance and stays put while stalled.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            hold_u <= '0;
            hold_l <= '0;
        end else if (accept) begin
            hold_u <= req_u;
            hold_l <= req_l;
        end
    end

    // Latency pipe: the last stage marks the cycle the memory data is valid.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            grant_sr <= '0;
        end else begin
            grant_sr[0] <= grant;
            for (int i = 1; i < LAT; i++) begin
                grant_sr[i] <= grant_sr[i-1];
            end
        end
    end

    assign fifo_push = grant_sr[LAT-1];
    assign fifo_pop  = resp_valid && resp_ready;

    resp_fifo #(
        .DEPTH (DEPTH)
    ) u_resp_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (fifo_push),
        .push_data ({u_data_out, l_data_out}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .not_empty (resp_valid),
        .count     (fifo_count)
    );

    assign resp_u         = fifo_head[RESP_W-1:32];
    assign resp_l         = fifo_head[31:0];
    assign fifo_count_dbg = fifo_count;

endmodule

// File: tb/tb_mem_port.sv
// Bench for mem_port: the bench plays pipeline, arbiter and shared memory.
// A request-level model (queues of accepted requests, grant-ordered expected
// responses, occupancy counts) predicts every handshake output each cycle.
module tb_mem_port;
    import mem_port_pkg::*;

    localparam int LAT   = MEM_LAT;
    localparam int DEPTH = PORT_DEPTH;

    // ---------------- clock / reset ----------------
    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, mem_req_now, mem_wait;
    data_in      req_u, req_l, u_data_in, l_data_in;
    logic [31:0] u_data_out, l_data_out, resp_u, resp_l;
    logic        resp_valid, resp_ready, interlock, busy;
    logic [1:0]  state_dbg;
    logic [2:0]  fifo_count_dbg;

    mem_port #(.LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
        .req_u(req_u), .req_l(req_l), .mem_req_now(mem_req_now), .mem_wait(mem_wait),
        .u_data_in(u_data_in), .l_data_in(l_data_in), .u_data_out(u_data_out),
        .l_data_out(l_data_out), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_u(resp_u), .resp_l(resp_l), .interlock(interlock), .busy(busy),
        .state_dbg(state_dbg), .fifo_count_dbg(fifo_count_dbg)
    );

    // ---------------- model / scoreboard state ----------------
    typedef struct {
        int          due;
        logic [31:0] u;
        logic [31:0] l;
    } ret_t;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    data_in      req_q_u[$];
    data_in      req_q_l[$];
    logic [63:0] exp_q[$];
    ret_t        ret_q[$];
    logic [31:0] got_q[$];
    int          acc_cnt, gnt_cnt, pop_cnt, avail;
    logic        last_push, mrn_pend;
    logic        wait_force = 1'b0;
    logic        wait_rand  = 1'b0;
    logic [31:0] mem_u[16];
    logic [31:0] mem_l[16];

    // snapshot of DUT outputs taken mid-cycle
    logic        s_ready, s_mrn, s_rv, s_busy, s_il, s_acc;
    logic [31:0] s_ru, s_rl;
    logic [2:0]  s_cnt;
    logic [1:0]  s_state;
    logic [15:0] s_addr_u;

    task automatic model_reset();
        req_q_u.delete(); req_q_l.delete(); exp_q.delete(); ret_q.delete();
        acc_cnt = 0; gnt_cnt = 0; pop_cnt = 0; avail = 0;
        last_push = 1'b0; mrn_pend = 1'b0;
    endtask

    task automatic rand_req();
        req_u.addr = 16'($urandom_range(0, 15));
        req_u.din  = $urandom;
        req_u.we   = 1'($urandom_range(0, 1));
        req_l.addr = 16'($urandom_range(0, 15));
        req_l.din  = $urandom;
        req_l.we   = 1'($urandom_range(0, 1));
    endtask

    // ---------------- driver + monitor: one clock cycle ----------------
    // Called just after a rising edge with this cycle's pipeline inputs set.
    task automatic cycle();
        ret_t        r;
        data_in      hu, hl;
        logic [31:0] du, dl;
        logic [63:0] e;
        logic        held_m, grant_m, exp_ready, acc, pop;
        cyc++;
        if (last_push) avail++;
        last_push = 1'b0;
        if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
            r = ret_q.pop_front();
            u_data_out = r.u;
            l_data_out = r.l;
            last_push  = 1'b1;
        end else begin
            u_data_out = $urandom;
            l_data_out = $urandom;
        end
        mem_wait = wait_force || (wait_rand && ($urandom_range(0, 2) == 0));
        @(negedge clk);
        s_ready = req_ready; s_mrn = mem_req_now; s_rv = resp_valid; s_busy = busy;
        s_il = interlock; s_ru = resp_u; s_rl = resp_l; s_cnt = fifo_count_dbg;
        s_state = state_dbg; s_addr_u = u_data_in.addr;

        held_m    = (acc_cnt != gnt_cnt);
        grant_m   = held_m && !mem_wait;
        exp_ready = (!held_m || grant_m) && ((acc_cnt - pop_cnt) < DEPTH);

        n_checks++;
        if (req_ready !== exp_ready) begin
            n_errors++; $display("FAIL req_ready cyc=%0d got=%0b exp=%0b", cyc, req_ready, exp_ready);
        end
        n_checks++;
        if (interlock !== (req_valid && !exp_ready)) begin
            n_errors++; $display("FAIL interlock cyc=%0d got=%0b exp=%0b", cyc, interlock, req_valid && !exp_ready);
        end
        n_checks++;
        if (busy !== ((acc_cnt - pop_cnt) != 0)) begin
            n_errors++; $display("FAIL busy cyc=%0d got=%0b exp=%0b", cyc, busy, (acc_cnt - pop_cnt) != 0);
        end
        n_checks++;
        if (mem_req_now !== mrn_pend) begin
            n_errors++; $display("FAIL mem_req_now cyc=%0d got=%0b exp=%0b", cyc, mem_req_now, mrn_pend);
        end
        n_checks++;
        if (resp_valid !== (avail > 0)) begin
            n_errors++; $display("FAIL resp_valid cyc=%0d got=%0b exp=%0b", cyc, resp_valid, avail > 0);
        end
        n_checks++;
        if (fifo_count_dbg !== 3'(avail)) begin
            n_errors++; $display("FAIL fifo_count cyc=%0d got=%0d exp=%0d", cyc, fifo_count_dbg, avail);
        end
        n_checks++;
        if (held_m) begin
            if (u_data_in !== req_q_u[0] || l_data_in !== req_q_l[0]) begin
                n_errors++; $display("FAIL held_req cyc=%0d got=%h/%h exp=%h/%h", cyc, u_data_in, l_data_in, req_q_u[0], req_q_l[0]);
            end
        end else if (u_data_in.we !== 1'b0 || l_data_in.we !== 1'b0) begin
            n_errors++; $display("FAIL idle_we cyc=%0d got=%0b/%0b exp=0/0", cyc, u_data_in.we, l_data_in.we);
        end

        acc = req_valid && exp_ready;
        pop = (avail > 0) && resp_ready;
        if (pop) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++; $display("FAIL resp_order cyc=%0d got=%h exp=none", cyc, {resp_u, resp_l});
            end else begin
                e = exp_q.pop_front();
                if ({resp_u, resp_l} !== e) begin
                    n_errors++; $display("FAIL resp_data cyc=%0d got=%h exp=%h", cyc, {resp_u, resp_l}, e);
                end
            end
            got_q.push_back(resp_u);
            pop_cnt++; avail--;
        end
        if (grant_m) begin
            hu = req_q_u.pop_front();
            hl = req_q_l.pop_front();
            if (hu.we) begin mem_u[hu.addr[3:0]] = hu.din; du = hu.din; end
            else du = mem_u[hu.addr[3:0]];
            if (hl.we) begin mem_l[hl.addr[3:0]] = hl.din; dl = hl.din; end
            else dl = mem_l[hl.addr[3:0]];
            r.due = cyc + LAT; r.u = du; r.l = dl;
            ret_q.push_back(r);
            exp_q.push_back({du, dl});
            gnt_cnt++;
        end
        if (acc) begin
            req_q_u.push_back(req_u);
            req_q_l.push_back(req_l);
            acc_cnt++;
        end
        mrn_pend = acc;
        s_acc    = acc;
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2;
        n_checks++;
        if (state_dbg !== ST_IDLE || mem_req_now !== 1'b0 || req_ready !== 1'b0) begin
            n_errors++; $display("FAIL rst_ctrl got=%0d/%0b/%0b exp=0/0/0", state_dbg, mem_req_now, req_ready);
        end
        n_checks++;
        if (u_data_in.we !== 1'b0 || l_data_in.we !== 1'b0 || busy !== 1'b0) begin
            n_errors++; $display("FAIL rst_we_busy got=%0b/%0b/%0b exp=0/0/0", u_data_in.we, l_data_in.we, busy);
        end
        n_checks++;
        if (resp_valid !== 1'b0 || resp_u !== 32'd0 || resp_l !== 32'd0) begin
            n_errors++; $display("FAIL rst_resp got=%0b/%h/%h exp=0/0/0", resp_valid, resp_u, resp_l);
        end
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b0;
        model_reset();
        cycle();
        n_checks++;
        if (s_state !== ST_IDLE || s_ready !== 1'b1) begin
            n_errors++; $display("FAIL rst_release got=%0d/%0b exp=%0d/1", s_state, s_ready, ST_IDLE);
        end
    endtask

    task automatic test_isolated_load();
        mem_u[1] = 32'h0000_1234;
        mem_l[2] = 32'h0000_5678;
        resp_ready = 1'b1;
        req_u = '{addr: 16'd1, din: 32'd0, we: 1'b0};
        req_l = '{addr: 16'd2, din: 32'd0, we: 1'b0};
        req_valid = 1'b1;
        cycle();
        req_valid = 1'b0;
        n_checks++;
        if (s_ready !== 1'b1) begin n_errors++; $display("FAIL iso_accept got=%0b exp=1", s_ready); end
        for (int c = 1; c <= 5; c++) begin
            cycle();
            n_checks++;
            if (s_mrn !== (c == 1)) begin n_errors++; $display("FAIL iso_mrn c=%0d got=%0b exp=%0b", c, s_mrn, c == 1); end
            if (c == 4) begin
                n_checks++;
                if (s_rv !== 1'b0) begin n_errors++; $display("FAIL iso_early c=4 got=%0b exp=0", s_rv); end
            end
            if (c == 5) begin
                n_checks++;
                if (s_rv !== 1'b1 || s_ru !== 32'h1234 || s_rl !== 32'h5678) begin
                    n_errors++; $display("FAIL iso_resp c=5 got=%0b/%h/%h exp=1/1234/5678", s_rv, s_ru, s_rl);
                end
            end
        end
    endtask

    task automatic test_wait_stall();
        mem_u[3] = 32'hCAFE_0003;
        resp_ready = 1'b1;
        req_u = '{addr: 16'd3, din: 32'd0, we: 1'b0};
        req_l = '{addr: 16'd4, din: 32'd0, we: 1'b0};
        req_valid = 1'b1;
        cycle();
        req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            wait_force = (c <= 3);
            cycle();
            n_checks++;
            if (s_mrn !== (c == 1)) begin n_errors++; $display("FAIL wait_mrn c=%0d got=%0b exp=%0b", c, s_mrn, c == 1); end
            if (c <= 4) begin
                n_checks++;
                if (s_addr_u !== 16'd3) begin n_errors++; $display("FAIL wait_addr c=%0d got=%0d exp=3", c, s_addr_u); end
            end
            if (c == 7) begin
                n_checks++;
                if (s_rv !== 1'b0) begin n_errors++; $display("FAIL wait_early c=7 got=%0b exp=0", s_rv); end
            end
            if (c == 8) begin
                n_checks++;
                if (s_rv !== 1'b1 || s_ru !== 32'hCAFE_0003) begin
                    n_errors++; $display("FAIL wait_resp c=8 got=%0b/%h exp=1/cafe0003", s_rv, s_ru);
                end
            end
        end
        wait_force = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int guard = 0;
        resp_ready = 1'b0;
        rand_req();
        req_valid = 1'b1;
        while (n < 4 && guard < 20) begin
            cycle();
            if (s_acc) begin n++; rand_req(); end
            guard++;
        end
        n_checks++;
        if (n != 4 || guard != 4) begin n_errors++; $display("FAIL b2b_accepts got=%0d in %0d exp=4 in 4", n, guard); end
        cycle();
        n_checks++;
        if (s_ready !== 1'b0 || s_il !== 1'b1) begin
            n_errors++; $display("FAIL b2b_full got=%0b/%0b exp=0/1", s_ready, s_il);
        end
        guard = 0;
        while (s_cnt != 3'd4 && guard < 20) begin cycle(); guard++; end
        n_checks++;
        if (s_cnt !== 3'd4 || s_ready !== 1'b0) begin
            n_errors++; $display("FAIL b2b_fill got=%0d/%0b exp=4/0", s_cnt, s_ready);
        end
        resp_ready = 1'b1;
        cycle();
        resp_ready = 1'b0;
        cycle();
        n_checks++;
        if (s_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_restore got=%0b exp=1", s_ready); end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        guard = 0;
        while (s_busy && guard < 40) begin cycle(); guard++; end
        n_checks++;
        if (s_busy !== 1'b0) begin n_errors++; $display("FAIL b2b_drain got=%0b exp=0", s_busy); end
    endtask

    task automatic test_push_pop_wrap();
        int i = 0;
        resp_ready = 1'b0;
        rand_req();
        req_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin cycle(); rand_req(); end
        req_valid = 1'b0;
        repeat (3) cycle();
        resp_ready = 1'b1;
        cycle();
        n_checks++;
        if (s_cnt !== 3'd2) begin n_errors++; $display("FAIL pp_before got=%0d exp=2", s_cnt); end
        resp_ready = 1'b0;
        cycle();
        n_checks++;
        if (s_cnt !== 3'd2) begin n_errors++; $display("FAIL pp_same got=%0d exp=2", s_cnt); end
        resp_ready = 1'b1;
        repeat (8) cycle();
        got_q.delete();
        for (int c = 0; c < 200 && got_q.size() < 8; c++) begin
            req_valid = (i < 8);
            req_u = '{addr: 16'(i), din: 32'(i + 1), we: 1'b1};
            req_l = '{addr: 16'(i), din: 32'(i + 101), we: 1'b1};
            resp_ready = 1'($urandom_range(0, 1));
            cycle();
            if (s_acc) i++;
        end
        req_valid = 1'b0;
        n_checks++;
        if (got_q.size() != 8) begin
            n_errors++; $display("FAIL wrap_count got=%0d exp=8", got_q.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                n_checks++;
                if (got_q[k] !== 32'(k + 1)) begin n_errors++; $display("FAIL wrap_order k=%0d got=%0d exp=%0d", k, got_q[k], k + 1); end
            end
        end
    endtask

    task automatic test_reset_mid();
        resp_ready = 1'b1;
        rand_req();
        req_valid = 1'b1;
        cycle(); rand_req();
        cycle();
        req_valid = 1'b0;
        cycle();
        #2;
        rstn = 1'b1;
        #1;
        n_checks++;
        if (state_dbg !== ST_IDLE || mem_req_now !== 1'b0 || req_ready !== 1'b0 || busy !== 1'b0 || resp_valid !== 1'b0) begin
            n_errors++; $display("FAIL midrst_async got=%0d/%0b/%0b/%0b/%0b exp=0/0/0/0/0", state_dbg, mem_req_now, req_ready, busy, resp_valid);
        end
        model_reset();
        @(posedge clk);
        #1;
        rstn = 1'b0;
        cycle();
        n_checks++;
        if (s_state !== ST_IDLE || s_ready !== 1'b1) begin
            n_errors++; $display("FAIL midrst_release got=%0d/%0b exp=0/1", s_state, s_ready);
        end
        for (int c = 0; c < 8; c++) begin
            cycle();
            n_checks++;
            if (s_rv !== 1'b0 || s_busy !== 1'b0) begin
                n_errors++; $display("FAIL midrst_stale c=%0d got=%0b/%0b exp=0/0", c, s_rv, s_busy);
            end
        end
        test_isolated_load();
    endtask

    task automatic test_random();
        int guard = 0;
        wait_rand = 1'b1;
        req_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!req_valid) begin
                req_valid = 1'($urandom_range(0, 1));
                rand_req();
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            cycle();
            if (s_acc) req_valid = 1'b0;
        end
        wait_rand = 1'b0;
        req_valid = 1'b0;
        resp_ready = 1'b1;
        while (s_busy && guard < 100) begin cycle(); guard++; end
        n_checks++;
        if (s_busy !== 1'b0 || exp_q.size() != 0) begin
            n_errors++; $display("FAIL rand_drain got=%0b/%0d exp=0/0", s_busy, exp_q.size());
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        req_valid = 1'b0; resp_ready = 1'b0; mem_wait = 1'b0;
        req_u = '0; req_l = '0; u_data_out = '0; l_data_out = '0;
        for (int i = 0; i < 16; i++) begin mem_u[i] = $urandom; mem_l[i] = $urandom; end
        model_reset();
        test_reset();
        test_isolated_load();
        test_wait_stall();
        test_back_to_back();
        test_push_pop_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t exp=finish before limit", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
